// File: rtl/score_bcd_counter.sv
// Game score accumulator holding a packed-BCD score.
// An add request runs a digit-serial BCD add, one digit per clock, starting at the units digit.
// The score saturates at all nines and raises a sticky overflow flag.
// Each 4-bit slice of bcd_o feeds a 7-segment decoder directly.
//
// Ports:
//   clk_i       system clock, rising edge
//   reset_i     synchronous active-high reset, highest priority
//   clear_i     synchronous score clear; also aborts an add in flight
//   add_en_i    add request, accepted only while ready_o is high
//   add_val_i   points to add; values above 9 are clamped to 9
//   ready_o     idle and able to accept add_en_i
//   done_o      one-cycle pulse on the cycle after an add commits or saturates
//   overflow_o  sticky saturation flag, cleared by clear_i or reset_i
//   bcd_o       committed score; digit i at [4i+3:4i], digit 0 is the units digit
module score_bcd_counter #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  clear_i,
  input  logic                  add_en_i,
  input  logic [3:0]            add_val_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic                  overflow_o,
  output logic [4*DIGITS-1:0]   bcd_o
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [0:0] {StIdle, StAdd} state_e;

  state_e          state_q;
  logic [W-1:0]    bcd_q;
  logic [W-1:0]    work_q;
  logic [3:0]      operand_q;
  logic [IdxW-1:0] idx_q;
  logic            carry_q;
  logic            ready_q;
  logic            done_q;
  logic            overflow_q;

  // Datapath for the digit being processed this cycle
  logic [3:0]      cur_digit;
  logic [4:0]      digit_sum;
  logic [3:0]      new_digit;
  logic            sum_carry;
  logic [W-1:0]    work_upd;
  logic            last_digit;
  logic [3:0]      add_val_clamped;

  assign add_val_clamped = (add_val_i > 4'd9) ? 4'd9 : add_val_i;
  assign last_digit      = (idx_q == IdxW'(DIGITS - 1));

  always_comb begin
    cur_digit = 4'd0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IdxW'(i)) cur_digit = work_q[4*i +: 4];
    end

    // The operand only enters at the units digit; higher digits just absorb the carry.
    // The worst case is 9 + 9 + 0 = 18, so one subtraction of 10 is enough.
    digit_sum = {1'b0, cur_digit}
              + ((idx_q == '0) ? {1'b0, operand_q} : 5'd0)
              + {4'd0, carry_q};

    if (digit_sum > 5'd9) begin
      new_digit = 4'(digit_sum - 5'd10);
      sum_carry = 1'b1;
    end else begin
      new_digit = digit_sum[3:0];
      sum_carry = 1'b0;
    end

    work_upd = work_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IdxW'(i)) work_upd[4*i +: 4] = new_digit;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      bcd_q      <= '0;
      work_q     <= '0;
      operand_q  <= 4'd0;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      // done_o is a single-cycle pulse unless a commit below sets it again
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (clear_i) begin
            // A clear wins over a simultaneous add request, which is dropped
            work_q     <= '0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
          end else if (add_en_i) begin
            operand_q <= add_val_clamped;
            work_q    <= bcd_q;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            ready_q   <= 1'b0;
            state_q   <= StAdd;
          end
        end

        StAdd: begin
          if (clear_i) begin
            // Abort: no commit and no done pulse
            work_q     <= '0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            ready_q    <= 1'b1;
            state_q    <= StIdle;
          end else if (!sum_carry) begin
            // The carry has died out, so the remaining digits are already final
            work_q  <= work_upd;
            bcd_q   <= work_upd;
            carry_q <= 1'b0;
            idx_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else if (!last_digit) begin
            work_q  <= work_upd;
            carry_q <= 1'b1;
            idx_q   <= idx_q + IdxW'(1);
          end else begin
            // Carry out of the top digit: pin the score at all nines
            work_q     <= {DIGITS{4'h9}};
            bcd_q      <= {DIGITS{4'h9}};
            overflow_q <= 1'b1;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            ready_q    <= 1'b1;
            done_q     <= 1'b1;
            state_q    <= StIdle;
          end
        end

        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o    = ready_q;
  assign done_o     = done_q;
  assign overflow_o = overflow_q;
  assign bcd_o      = bcd_q;

endmodule

// File: doc/score_bcd_counter.md
Name: score_bcd_counter

Overview:
- Game score accumulator for the space shooter. Holds the score as packed BCD digits and adds a 0–9 point value per hit event, one digit per clock.
- Sits directly upstream of the per-digit 7-segment decoders. Each 4-bit slice of bcd drives one decoder's 4-bit input, so no binary-to-BCD conversion is needed.
- Saturates at all-nines and flags overflow.

Parameters:
- DIGITS, 4, number of BCD digits held and output (1..6; one per HEX display).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  synchronous score clear (new game); one-cycle pulse or level.
- add_en  input  1  add request; accepted only on a cycle with ready=1.
- add_val  input  4  points to add (BCD 0–9); values 10–15 are clamped to 9.
- ready  output  1  high when idle and able to accept add_en.
- done  output  1  one-cycle pulse on the cycle after an add commits.
- overflow  output  1  sticky; set when an add saturates the score.
- bcd  output  4*DIGITS  committed score; digit i at bits [4i+3:4i]; digit 0 = units.

Behaviour:
- Reset (takes priority over everything): bcd=0, work register=0, ready=1, done=0, overflow=0, state=IDLE, idx=0, carry=0.
- State IDLE (ready=1):
  - clear=1 → work=0, bcd=0, overflow=0; any add_en on the same cycle is dropped.
  - Else add_en=1 → latch operand = min(add_val,9), copy bcd into work, idx=0, state→ADD.
  - add_en when ready=0 is ignored and not queued.
- State ADD (ready=0): each edge processes digit idx.
  - s = work[idx] + (idx==0 ? operand : 0) + carry.
  - If s>9: digit = s−10 and carry=1; else digit = s and carry=0.
  - If carry=0 after processing → commit: bcd←work including this digit, state→IDLE, done=1 next cycle.
  - If carry=1 and idx<DIGITS−1 → idx+1, stay in ADD.
  - If carry=1 and idx==DIGITS−1 → saturate: bcd←all digits 9, work←all 9, overflow=1, state→IDLE, done=1.
- Latency: add_en accepted at edge E. The commit edge is E+k, where k = 1 + number of digits the carry ripples into (max DIGITS). ready is low for k cycles; done is high in the cycle following E+k.
- bcd is stable during ADD: it changes only on a commit, saturate, clear or reset edge. Intermediate digits are never visible downstream.
- add_val=0 is still a full transaction: one cycle busy, done pulses, bcd unchanged.
- clear=1 during ADD aborts the add on that edge: work=0, bcd=0, overflow=0, state→IDLE, no done pulse.
- At saturation (all nines) any further add of ≥1 re-saturates, keeps overflow=1 and pulses done. An add of 0 leaves bcd unchanged.
- done is never high in two consecutive cycles.
- Digits outside 0–9 cannot arise internally. Every bcd digit is always a valid decoder input 0–9.

Test Plan:
- Reset then idle 5 cycles → bcd=0x0000, ready=1, done=0, overflow=0. Assert reset mid-ADD (score 0999, add 9, reset at 2nd busy cycle) → next cycle bcd=0, ready=1, no done.
- From 0000, add_en with add_val=3 → ready low exactly 1 cycle, bcd=0x0003 after commit, done pulses once. Then add 8 → bcd=0x0011, ready low 2 cycles.
- From 0999, add 9 → ready low 4 cycles, bcd holds 0x0999 until commit, then 0x1008, done one pulse.
- From 9995, add 7 → bcd=0x9999, overflow=1 sticky. Add 1 → bcd stays 0x9999, done pulses. Then clear → bcd=0x0000, overflow=0.
- add_val=12 from 0000 → bcd=0x0009. add_en asserted during ADD is ignored: score increments by first operand only. clear and add_en in the same IDLE cycle → bcd=0, no done.
- Back-to-back: add_en held high with add_val=1 for 30 cycles from 0000 → one add per ready window. bcd increments by 1 per done pulse, and the done count equals the final bcd value.
